// File: rtl/sw_alloc_pkg.sv
// Shared constants and FSM encoding for the switch allocator.
package sw_alloc_pkg;

  localparam int CW_DEF    = 3;
  localparam int N_IN_DEF  = 5;
  localparam int N_OUT_DEF = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/sw_alloc_if.sv
// Request/grant and crossbar-select bundle between the router ports and the allocator.
interface sw_alloc_if
  import sw_alloc_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int CW    = CW_DEF
);

  logic [N_IN-1:0]     sw_req;
  logic [N_IN*CW-1:0]  sw_chnl;
  logic [N_IN-1:0]     sw_gnt;
  logic [N_OUT-1:0]    out_rdy;
  logic [N_OUT-1:0]    out_vld;
  logic [N_OUT*CW-1:0] out_sel;

  modport master (
    output sw_req, sw_chnl, out_rdy,
    input  sw_gnt, out_vld, out_sel
  );

  modport slave (
    input  sw_req, sw_chnl, out_rdy,
    output sw_gnt, out_vld, out_sel
  );

endinterface

// File: rtl/sw_alloc_rr_arb.sv
// Round-robin picker: lowest requester at or after the pointer, wrapping to 0.
module rr_arb #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  assign o_any = |i_req;

  // Wrapped requesters (below ptr) are picked first, then overridden by any at/after ptr;
  // descending scans leave the lowest index of each group as the final pick.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i] && (int'(i_ptr) > i)) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i] && (i >= int'(i_ptr))) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = W'(i);
      end
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator: one round-robin IDLE/BUSY FSM per output, packet-locked grants.
//
//   state | meaning
//   IDLE  | output free; allocates on out_rdy with an eligible requester
//   BUSY  | output locked to r_win until that input drops its request
module sw_alloc
  import sw_alloc_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int CW    = CW_DEF
) (
  input logic      clk,
  input logic      reset,
  sw_alloc_if.slave bus
);

  state_e              r_state [N_OUT];
  logic [CW-1:0]       r_win   [N_OUT];
  logic [CW-1:0]       r_sel   [N_OUT];
  logic [CW-1:0]       r_ptr   [N_OUT];
  logic [N_OUT-1:0]    r_vld;
  logic [N_IN-1:0]     r_gnt;

  logic [N_IN-1:0]     w_cand    [N_OUT];
  logic [N_IN-1:0]     w_arb_gnt [N_OUT];
  logic [CW-1:0]       w_arb_idx [N_OUT];
  logic                w_arb_any [N_OUT];
  logic [N_OUT-1:0]    w_take;
  logic [N_OUT-1:0]    w_rel;
  logic [N_IN-1:0]     w_set;
  logic [N_IN-1:0]     w_clr;
  logic [N_OUT*CW-1:0] w_sel_flat;

  // Candidates for output o: live, not already granted, aimed at o (out-of-range channels never match)
  always_comb begin
    logic [CW-1:0] w_chnl;
    w_chnl = '0;
    for (int o = 0; o < N_OUT; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_chnl       = bus.sw_chnl[i*CW +: CW];
        w_cand[o][i] = bus.sw_req[i] && !r_gnt[i] &&
                       (int'(w_chnl) < N_OUT) && (int'(w_chnl) == o);
      end
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_arb
    rr_arb #(.N(N_IN), .W(CW)) u_arb (
      .i_req (w_cand[o]),
      .i_ptr (r_ptr[o]),
      .o_gnt (w_arb_gnt[o]),
      .o_idx (w_arb_idx[o]),
      .o_any (w_arb_any[o])
    );
  end

  // Allocation and release events per output, folded into per-input grant set/clear
  always_comb begin
    w_take = '0;
    w_rel  = '0;
    w_set  = '0;
    w_clr  = '0;
    for (int o = 0; o < N_OUT; o++) begin
      w_take[o] = (r_state[o] == IDLE) && bus.out_rdy[o] && w_arb_any[o];
      w_rel[o]  = (r_state[o] == BUSY) && !bus.sw_req[r_win[o]];
      for (int i = 0; i < N_IN; i++) begin
        if (w_take[o] && w_arb_gnt[o][i]) w_set[i] = 1'b1;
        if (w_rel[o] && (r_win[o] == CW'(i))) w_clr[i] = 1'b1;
      end
    end
  end

  // Output FSMs; a release edge always lands in IDLE, so no same-edge regrant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < N_OUT; o++) begin
        r_state[o] <= IDLE;
        r_win[o]   <= '0;
        r_sel[o]   <= '0;
        r_ptr[o]   <= '0;
      end
      r_vld <= '0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        if (w_take[o]) begin
          r_state[o] <= BUSY;
          r_win[o]   <= w_arb_idx[o];
          r_sel[o]   <= w_arb_idx[o];
          r_vld[o]   <= 1'b1;
          r_ptr[o]   <= (w_arb_idx[o] == CW'(N_IN - 1)) ? '0 : w_arb_idx[o] + CW'(1);
        end else if (w_rel[o]) begin
          r_state[o] <= IDLE;
          r_sel[o]   <= '0;
          r_vld[o]   <= 1'b0;
        end
      end
    end
  end

  // Grants: an input can only win on the output it points at, and release needs its request low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_gnt <= '0;
    else        r_gnt <= (r_gnt & ~w_clr) | w_set;
  end

  // Flatten per-output selects onto the bus
  always_comb begin
    w_sel_flat = '0;
    for (int o = 0; o < N_OUT; o++) w_sel_flat[o*CW +: CW] = r_sel[o];
  end

  assign bus.sw_gnt  = r_gnt;
  assign bus.out_vld = r_vld;
  assign bus.out_sel = w_sel_flat;

endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: directed scenarios plus randomized traffic
// against a per-output round-robin reference model.
module tb_sw_alloc;

  localparam int N_IN  = 5;
  localparam int N_OUT = 5;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sw_alloc_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CW(CW)) bus ();

  sw_alloc #(.N_IN(N_IN), .N_OUT(N_OUT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus state
  int t_req  [N_IN];
  int t_chnl [N_IN];
  int t_rdy  [N_OUT];

  // reference model state
  int m_busy [N_OUT];
  int m_win  [N_OUT];
  int m_ptr  [N_OUT];
  int m_gnt  [N_IN];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int o = 0; o < N_OUT; o++) begin
      m_busy[o] = 0; m_win[o] = 0; m_ptr[o] = 0;
    end
    for (int i = 0; i < N_IN; i++) m_gnt[i] = 0;
  endfunction

  // One clock edge of the allocator rules, using the inputs held across that edge.
  function automatic void model_edge();
    int g_old [N_IN];
    int idx;
    g_old = m_gnt;
    for (int o = 0; o < N_OUT; o++) begin
      if (m_busy[o] != 0) begin
        if (t_req[m_win[o]] == 0) begin
          m_busy[o] = 0;
          m_gnt[m_win[o]] = 0;
        end
      end else if (t_rdy[o] != 0) begin
        for (int k = 0; k < N_IN; k++) begin
          idx = (m_ptr[o] + k) % N_IN;
          if (t_req[idx] != 0 && t_chnl[idx] == o && g_old[idx] == 0) begin
            m_busy[o] = 1;
            m_win[o]  = idx;
            m_gnt[idx] = 1;
            m_ptr[o]  = (idx + 1) % N_IN;
            break;
          end
        end
      end
    end
  endfunction

  task automatic drive();
    logic [N_IN-1:0]    r;
    logic [N_IN*CW-1:0] c;
    logic [N_OUT-1:0]   y;
    r = '0; c = '0; y = '0;
    for (int i = 0; i < N_IN; i++) begin
      r[i] = (t_req[i] != 0);
      c[i*CW +: CW] = CW'(t_chnl[i]);
    end
    for (int o = 0; o < N_OUT; o++) y[o] = (t_rdy[o] != 0);
    bus.sw_req  = r;
    bus.sw_chnl = c;
    bus.out_rdy = y;
  endtask

  task automatic check_outputs(input string tag);
    logic [N_IN-1:0]     eg;
    logic [N_OUT-1:0]    ev;
    logic [N_OUT*CW-1:0] es;
    eg = '0; ev = '0; es = '0;
    for (int i = 0; i < N_IN; i++) eg[i] = (m_gnt[i] != 0);
    for (int o = 0; o < N_OUT; o++) begin
      if (m_busy[o] != 0) begin
        ev[o] = 1'b1;
        es[o*CW +: CW] = CW'(m_win[o]);
      end
    end
    check_eq({tag, ".gnt"}, 32'(bus.sw_gnt),  32'(eg));
    check_eq({tag, ".vld"}, 32'(bus.out_vld), 32'(ev));
    check_eq({tag, ".sel"}, 32'(bus.out_sel), 32'(es));
  endtask

  task automatic step(input string tag);
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Asserted between edges; outputs must clear with no clock edge in between.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_inputs(input int rdy);
    for (int i = 0; i < N_IN; i++) begin t_req[i] = 0; t_chnl[i] = 0; end
    for (int o = 0; o < N_OUT; o++) t_rdy[o] = rdy;
  endtask

  int order [$];
  int exp_ord [4] = '{1, 3, 4, 1};
  int hold [N_IN];
  logic prev_vld0;

  initial begin
    reset = 1'b1;
    clear_inputs(1);
    model_reset();
    drive();
    #2;
    do_reset("rst0");

    // single request, then drop
    t_req[0] = 1; t_chnl[0] = 2;
    step("single");
    check_eq("single_gnt", 32'(bus.sw_gnt), 32'h01);
    check_eq("single_vld2", 32'(bus.out_vld[2]), 32'h1);
    check_eq("single_sel2", 32'(bus.out_sel[2*CW +: CW]), 32'h0);
    step("single_hold");
    step("single_hold");
    t_req[0] = 0;
    step("single_drop");
    check_eq("drop_gnt", 32'(bus.sw_gnt), 32'h0);
    check_eq("drop_vld", 32'(bus.out_vld), 32'h0);

    // parallel grants to different outputs
    t_req[0] = 1; t_chnl[0] = 1;
    t_req[2] = 1; t_chnl[2] = 3;
    step("par");
    check_eq("par_gnt", 32'(bus.sw_gnt), 32'h05);
    check_eq("par_sel1", 32'(bus.out_sel[1*CW +: CW]), 32'h0);
    check_eq("par_sel3", 32'(bus.out_sel[3*CW +: CW]), 32'h2);
    clear_inputs(1);
    step("par_drop");

    // output not ready
    t_req[1] = 1; t_chnl[1] = 4; t_rdy[4] = 0;
    for (int k = 0; k < 5; k++) begin
      step("nrdy");
      check_eq("nrdy_gnt1", 32'(bus.sw_gnt[1]), 32'h0);
    end
    t_rdy[4] = 1;
    step("nrdy_go");
    check_eq("nrdy_go_gnt1", 32'(bus.sw_gnt[1]), 32'h1);
    clear_inputs(1);
    step("nrdy_drop");

    // invalid channel is never granted and does not block
    t_req[0] = 1; t_chnl[0] = 7;
    t_req[1] = 1; t_chnl[1] = 0;
    for (int k = 0; k < 4; k++) begin
      step("inv");
      check_eq("inv_gnt", 32'(bus.sw_gnt), 32'h02);
    end
    clear_inputs(1);
    step("inv_drop");

    // reset mid-packet, then the pointer restarts from 0
    t_req[0] = 1; t_chnl[0] = 2;
    step("rmid");
    step("rmid");
    check_eq("rmid_busy", 32'(bus.out_vld[2]), 32'h1);
    do_reset("rmid_rst");
    check_eq("rmid_gnt0", 32'(bus.sw_gnt), 32'h0);
    check_eq("rmid_sel0", 32'(bus.out_sel), 32'h0);
    t_req[3] = 1; t_chnl[3] = 2;
    step("rmid_after");
    check_eq("rmid_ptr0", 32'(bus.out_sel[2*CW +: CW]), 32'h0);
    clear_inputs(1);
    step("rmid_drop");

    // contention on output 0 from inputs 1,3,4, each releasing after 9 granted cycles
    do_reset("cont_rst");
    clear_inputs(1);
    for (int i = 0; i < N_IN; i++) hold[i] = 0;
    t_req[1] = 1; t_req[3] = 1; t_req[4] = 1;
    prev_vld0 = 1'b0;
    for (int s = 0; s < 80 && order.size() < 4; s++) begin
      step("cont");
      if (bus.out_vld[0] && !prev_vld0) order.push_back(int'(bus.out_sel[CW-1:0]));
      prev_vld0 = bus.out_vld[0];
      for (int i = 1; i < N_IN; i++) begin
        if (i == 2) continue;
        if (t_req[i] == 0) begin
          t_req[i] = 1;
          hold[i] = 0;
        end else if (m_gnt[i] != 0) begin
          hold[i]++;
          if (hold[i] == 9) t_req[i] = 0;
        end
      end
    end
    check_eq("cont_cnt", 32'(order.size() >= 4), 32'h1);
    for (int k = 0; k < 4; k++)
      if (k < order.size()) check_eq("cont_ord", 32'(order[k]), 32'(exp_ord[k]));
    clear_inputs(1);
    step("cont_drop");
    step("cont_drop");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (t_req[i] != 0) begin
          if (m_gnt[i] != 0) begin
            if ($urandom_range(0, 5) == 0) t_req[i] = 0;
            else if ($urandom_range(0, 9) == 0) t_chnl[i] = int'($urandom_range(0, 7));
          end else begin
            if ($urandom_range(0, 7) == 0) t_req[i] = 0;
            else if ($urandom_range(0, 9) == 0) t_chnl[i] = int'($urandom_range(0, 6));
          end
        end else if ($urandom_range(0, 2) == 0) begin
          t_req[i]  = 1;
          t_chnl[i] = int'($urandom_range(0, 6));
        end
      end
      for (int o = 0; o < N_OUT; o++) t_rdy[o] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if (n % 150 == 149) do_reset("rnd_rst");
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sw_alloc.md
SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 Parameter N_IN, default 5: number of rx (input) ports.
REQ-002 Parameter N_OUT, default 5: number of tx (output) ports; N_OUT <= 8.
REQ-003 Parameter CW, default 3: width of a channel/port index.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sw_req  input  N_IN  per-input switch request, level, held until granted or withdrawn.
REQ-007 sw_chnl  input  N_IN*CW  per-input requested output index, slice i = bits [i*CW +: CW].
REQ-008 sw_gnt  output  N_IN  per-input grant, registered, one-hot per output.
REQ-009 out_rdy  input  N_OUT  per-output tx idle/ready; allocation to output o only when out_rdy[o]=1.
REQ-010 out_vld  output  N_OUT  per-output connection active, registered.
REQ-011 out_sel  output  N_OUT*CW  per-output crossbar select (winning input index), registered.

Function
REQ-012 Each output o SHALL run an independent FSM with states IDLE and BUSY.
REQ-013 IDLE->BUSY SHALL occur on the edge where out_rdy[o]=1 and at least one input i has sw_req[i]=1, sw_chnl slice i = o, and sw_gnt[i]=0.
REQ-014 On that edge: out_vld[o]=1, out_sel[o]=winner, sw_gnt[winner]=1; latency request-to-grant = 1 cycle minimum.
REQ-015 Winner SHALL be chosen round-robin: first requester at or after ptr[o], wrapping N_IN-1 -> 0.
REQ-016 ptr[o] SHALL update to (winner+1) mod N_IN only on a grant edge; unchanged otherwise.
REQ-017 BUSY SHALL hold out_sel, out_vld and the grant (packet lock) while sw_req[winner]=1, regardless of other requests or sw_chnl changes.
REQ-018 BUSY->IDLE SHALL occur on the edge after sw_req[winner] samples 0; sw_gnt[winner] and out_vld[o] clear on that same edge.
REQ-019 Output SHALL spend at least one cycle in IDLE between packets (no same-edge release and regrant).
REQ-020 An input SHALL hold at most one grant; a request with sw_chnl >= N_OUT SHALL never be granted and SHALL not block others.
REQ-021 Request withdrawn before grant SHALL be dropped without side effects; ptr unchanged.
REQ-022 Simultaneous requests from different inputs to different outputs SHALL all be granted on the same edge.
REQ-023 out_rdy[o] SHALL be ignored while BUSY (affects allocation only).
REQ-024 out_sel[o] SHALL read 0 whenever out_vld[o]=0.

Reset
REQ-025 reset=0 SHALL immediately force all FSMs IDLE, sw_gnt=0, out_vld=0, out_sel=0, all ptr=0.
REQ-026 Reset mid-packet SHALL drop the connection; after release, arbitration restarts from ptr=0 on the first clk edge.

Structure
REQ-027 Shared package SHALL hold CW, default N_IN/N_OUT and FSM state encodings (IDLE=0, BUSY=1).
REQ-028 One sub-module rr_arb (N_IN-wide request vector, pointer -> one-hot grant, winner index, any) SHALL be instantiated per output.
REQ-029 Per-input request filtering (sw_req & chnl==o & ~sw_gnt & chnl<N_OUT) SHALL be combinational in sw_alloc.

Verification
REQ-030 Single: in 0 reqs chnl 2, out_rdy=all 1 -> next edge sw_gnt=00001, out_vld[2]=1, out_sel[2]=0; drop req -> both clear next edge.
REQ-031 Contention: ins 1,3,4 all req chnl 0 continuously, each releasing after 9 cycles -> grant order 1,3,4,1 with one IDLE cycle between.
REQ-032 Parallel: in 0->chnl 1, in 2->chnl 3 same cycle -> both granted same edge, out_sel[1]=0, out_sel[3]=2.
REQ-033 Not ready: in 1 reqs chnl 4, out_rdy[4]=0 for 5 cycles -> no grant; grant 1 cycle after out_rdy[4]=1.
REQ-034 Invalid: in 0 reqs chnl 7 (N_OUT=5), in 1 reqs chnl 0 -> only sw_gnt[1]; sw_gnt[0] never asserts.
REQ-035 Reset mid-packet: assert reset while out 2 BUSY -> sw_gnt, out_vld, out_sel zero without clk edge; ptr=0 after release.
